// File: rtl/rx_sample_arbiter_if.sv
// rx_sample_arbiter_if
//   Bundles the receiver-side sample inputs and the merged output stream of
//   rx_sample_arbiter.
//   slave  modport : arbiter view (receiver inputs in, merged output out)
//   master modport : environment view (drives receivers, consumes output)
//   rx_strobe/rx_enable : per-channel sample-available level / enable
//   rx_real/rx_imag     : packed signed 24-bit I/Q, channel i at [24i+23:24i]
//   overflow_clear      : pulse clearing all sticky overflow flags
//   out_valid/out_ready : output handshake
//   out_chan/out_real/out_imag : merged sample and its source channel
//   overflow            : sticky per-channel overrun flags
interface rx_sample_arbiter_if #(
    parameter int NRX = 4
);
    localparam int DATA_W = 24;

    logic [NRX-1:0]        rx_strobe;
    logic [DATA_W*NRX-1:0] rx_real;
    logic [DATA_W*NRX-1:0] rx_imag;
    logic [NRX-1:0]        rx_enable;
    logic                  overflow_clear;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0]            out_chan;
    logic signed [DATA_W-1:0] out_real;
    logic signed [DATA_W-1:0] out_imag;
    logic [NRX-1:0]        overflow;

    modport slave (
        input  rx_strobe, rx_real, rx_imag, rx_enable, overflow_clear, out_ready,
        output out_valid, out_chan, out_real, out_imag, overflow
    );

    modport master (
        output rx_strobe, rx_real, rx_imag, rx_enable, overflow_clear, out_ready,
        input  out_valid, out_chan, out_real, out_imag, overflow
    );
endinterface

// File: rtl/rx_sample_arbiter.sv
// rx_sample_arbiter
//   Merges NRX receiver channels into a single I/Q sample stream. Each
//   channel's rising strobe captures its sample into a hold register; a
//   round-robin arbiter moves one held sample per cycle into the output
//   register whenever that register is free.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : rx_sample_arbiter_if.slave (receiver inputs, output stream,
//           sticky overflow flags)
module rx_sample_arbiter #(
    parameter int NRX = 4
) (
    input logic              clock,
    input logic              reset,
    rx_sample_arbiter_if.slave bus
);
    localparam int DATA_W = 24;
    localparam int IW     = (NRX > 1) ? $clog2(NRX) : 1;

    logic [NRX-1:0] strobe_hist;
    logic [NRX-1:0] pending;
    logic [NRX-1:0] capture;
    logic [NRX-1:0] eligible;
    logic [NRX-1:0] grant_oh;
    logic [NRX-1:0] ovf_event;
    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  grant_idx;
    logic           grant_vld;
    logic           out_free;

    logic signed [DATA_W-1:0] hold_real [NRX];
    logic signed [DATA_W-1:0] hold_imag [NRX];

    // Stage 0: edge detect, eligibility and round-robin grant
    always_comb begin
        capture  = bus.rx_strobe & ~strobe_hist & bus.rx_enable;
        // A channel being disabled this cycle loses its held sample, so it
        // must not win the grant either.
        eligible = pending & bus.rx_enable;
        out_free = ~bus.out_valid | bus.out_ready;
    end

    always_comb begin
        logic [IW-1:0] cand;
        int            c;
        cand      = '0;
        c         = 0;
        grant_vld = 1'b0;
        grant_idx = last_grant;
        grant_oh  = '0;
        for (int k = 1; k <= NRX; k++) begin
            c = int'(last_grant) + k;
            if (c >= NRX) c = c - NRX;
            cand = IW'(c);
            if (out_free && !grant_vld && eligible[cand]) begin
                grant_vld      = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

    // A capture that lands on the very cycle its channel is granted is a
    // clean hand-off, not an overrun.
    always_comb ovf_event = capture & pending & ~grant_oh;

    // Stage 1: hold registers, pending/overflow state and output register
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_hist   <= '1;
            pending       <= '0;
            overflow_rst();
            last_grant    <= IW'(NRX - 1);
            bus.out_valid <= 1'b0;
            bus.out_chan  <= '0;
            bus.out_real  <= '0;
            bus.out_imag  <= '0;
            for (int i = 0; i < NRX; i++) begin
                hold_real[i] <= '0;
                hold_imag[i] <= '0;
            end
        end else begin
            strobe_hist  <= bus.rx_strobe;
            bus.overflow <= (bus.overflow & ~{NRX{bus.overflow_clear}}) | ovf_event;

            for (int i = 0; i < NRX; i++) begin
                if (!bus.rx_enable[i]) begin
                    pending[i] <= 1'b0;
                end else if (capture[i]) begin
                    pending[i] <= 1'b1;
                end else if (grant_oh[i]) begin
                    pending[i] <= 1'b0;
                end
                if (capture[i]) begin
                    hold_real[i] <= $signed(bus.rx_real[DATA_W*i +: DATA_W]);
                    hold_imag[i] <= $signed(bus.rx_imag[DATA_W*i +: DATA_W]);
                end
            end

            if (out_free) begin
                if (grant_vld) begin
                    bus.out_valid <= 1'b1;
                    bus.out_chan  <= 3'(grant_idx);
                    bus.out_real  <= hold_real[grant_idx];
                    bus.out_imag  <= hold_imag[grant_idx];
                    last_grant    <= grant_idx;
                end else begin
                    bus.out_valid <= 1'b0;
                end
            end
        end
    end

    task automatic overflow_rst();
        bus.overflow <= '0;
    endtask
endmodule

// File: tb/tb_rx_sample_arbiter.sv
// tb_rx_sample_arbiter
//   Directed scenarios for latency, arbitration order, backpressure, overrun,
//   enable drop and reset behaviour, followed by a randomized run compared
//   cycle by cycle against a behavioural model of the merging rules.
module tb_rx_sample_arbiter;
    localparam int NRX = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rx_sample_arbiter_if #(.NRX(NRX)) bus ();

    rx_sample_arbiter #(.NRX(NRX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [NRX-1:0] m_pend, m_prev, m_ovf;
    int             m_hr [NRX];
    int             m_hi [NRX];
    int             m_last;
    logic           m_ov;
    int             m_oc, m_or, m_oi;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_sample(input int ch, input logic [23:0] re, input logic [23:0] im);
        bus.rx_real[24*ch +: 24] = re;
        bus.rx_imag[24*ch +: 24] = im;
    endtask

    task automatic idle_inputs();
        bus.rx_strobe      = '0;
        bus.rx_enable      = '1;
        bus.overflow_clear = 1'b0;
        bus.out_ready      = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx_strobe = 4'($urandom);
        bus.rx_real = 96'({$urandom, $urandom, $urandom});
        bus.rx_imag = 96'({$urandom, $urandom, $urandom});
        bus.rx_enable = '1;
        bus.out_ready = 1'b1;
        bus.overflow_clear = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_chan !== 3'd0 || bus.out_real !== 24'sd0 ||
            bus.out_imag !== 24'sd0 || bus.overflow !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b chan=%0d re=%h im=%h ovf=%b, required all zero",
                     bus.out_valid, bus.out_chan, bus.out_real, bus.out_imag, bus.overflow);
        end
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_no_output: valid=%b, required 0", bus.out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_idle_latency();
        do_reset();
        tick();
        set_sample(2, 24'h123456, 24'hFEDCBA);
        bus.rx_strobe[2] = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_t1: valid=%b, required 0", bus.out_valid);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 3'd2 ||
            bus.out_real !== 24'sh123456 || bus.out_imag !== 24'shFEDCBA) begin
            n_fail++;
            $display("FAIL latency_t2: valid=%b chan=%0d re=%h im=%h, required 1 2 123456 fedcba",
                     bus.out_valid, bus.out_chan, bus.out_real, bus.out_imag);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_t3: valid=%b, required 0", bus.out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < NRX; c++) set_sample(c, 24'(24'h100000 + c), 24'(24'h200000 + c));
        bus.rx_strobe = '1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b, required 0", bus.out_valid);
        end
        for (int k = 0; k < NRX; k++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_chan !== 3'(k) ||
                bus.out_real !== 24'(24'h100000 + k) || bus.out_imag !== 24'(24'h200000 + k)) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: valid=%b chan=%0d re=%h, required 1 %0d %h",
                         k, bus.out_valid, bus.out_chan, bus.out_real, k, 24'h100000 + k);
            end
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: valid=%b, required 0", bus.out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        set_sample(1, 24'h0A0A0A, 24'h0B0B0B);
        bus.rx_strobe[1] = 1'b1;
        tick();
        bus.rx_strobe[1] = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            case (k)
                2: begin set_sample(1, 24'h111111, 24'h222222); bus.rx_strobe[1] = 1'b1; end
                3: bus.rx_strobe[1] = 1'b0;
                5: begin set_sample(1, 24'h333333, 24'h444444); bus.rx_strobe[1] = 1'b1; end
                6: bus.rx_strobe[1] = 1'b0;
                default: ;
            endcase
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_chan !== 3'd1 ||
                bus.out_real !== 24'sh0A0A0A || bus.out_imag !== 24'sh0B0B0B) begin
                n_fail++;
                $display("FAIL stall_stable[%0d]: valid=%b chan=%0d re=%h im=%h, required 1 1 0a0a0a 0b0b0b",
                         k, bus.out_valid, bus.out_chan, bus.out_real, bus.out_imag);
            end
        end
        n_checks++;
        if (bus.overflow !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_overflow: overflow=%b, required 0010", bus.overflow);
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 3'd1 ||
            bus.out_real !== 24'sh333333 || bus.out_imag !== 24'sh444444) begin
            n_fail++;
            $display("FAIL stall_newest: valid=%b chan=%0d re=%h im=%h, required 1 1 333333 444444",
                     bus.out_valid, bus.out_chan, bus.out_real, bus.out_imag);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: valid=%b, required 0", bus.out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_strobe_through_reset();
        idle_inputs();
        reset = 1'b1;
        bus.rx_strobe[3] = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL held_strobe[%0d]: valid=%b, required 0", k, bus.out_valid);
            end
        end
        bus.rx_strobe[3] = 1'b0;
        tick();
        set_sample(3, 24'h765432, 24'h800001);
        bus.rx_strobe[3] = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 3'd3 ||
            bus.out_real !== 24'sh765432 || bus.out_imag !== 24'sh800001) begin
            n_fail++;
            $display("FAIL held_strobe_next_edge: valid=%b chan=%0d re=%h im=%h, required 1 3 765432 800001",
                     bus.out_valid, bus.out_chan, bus.out_real, bus.out_imag);
        end
        idle_inputs();
    endtask

    task automatic test_overflow_clear();
        do_reset();
        bus.out_ready = 1'b0;
        set_sample(0, 24'h000001, 24'h000002);
        bus.rx_strobe[0] = 1'b1;
        tick();
        bus.rx_strobe[0] = 1'b0;
        tick();
        set_sample(0, 24'h000003, 24'h000004);
        bus.rx_strobe[0] = 1'b1;
        tick();
        bus.rx_strobe[0] = 1'b0;
        tick();
        n_checks++;
        if (bus.overflow[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_before: overflow[0]=%b, required 0", bus.overflow[0]);
        end
        set_sample(0, 24'h000005, 24'h000006);
        bus.rx_strobe[0] = 1'b1;
        bus.overflow_clear = 1'b1;
        tick();
        n_checks++;
        if (bus.overflow[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_clear_same_cycle: overflow[0]=%b, required 1", bus.overflow[0]);
        end
        bus.rx_strobe[0] = 1'b0;
        tick();
        n_checks++;
        if (bus.overflow[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear_next: overflow[0]=%b, required 0", bus.overflow[0]);
        end
        idle_inputs();
    endtask

    task automatic test_enable_drop();
        do_reset();
        bus.out_ready = 1'b0;
        set_sample(0, 24'h0D0D0D, 24'h0E0E0E);
        bus.rx_strobe[0] = 1'b1;
        tick();
        bus.rx_strobe[0] = 1'b0;
        tick();
        set_sample(1, 24'h5A5A5A, 24'hA5A5A5);
        bus.rx_strobe[1] = 1'b1;
        tick();
        bus.rx_strobe[1] = 1'b0;
        bus.rx_enable[1] = 1'b0;
        tick();
        bus.rx_enable[1] = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 3'd0 || bus.out_real !== 24'sh0D0D0D) begin
            n_fail++;
            $display("FAIL enable_drop_output_kept: valid=%b chan=%0d re=%h, required 1 0 0d0d0d",
                     bus.out_valid, bus.out_chan, bus.out_real);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_drop_discard[%0d]: valid=%b chan=%0d, required valid 0",
                         k, bus.out_valid, bus.out_chan);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        bus.out_ready = 1'b0;
        set_sample(0, 24'h010101, 24'h020202);
        set_sample(1, 24'h030303, 24'h040404);
        bus.rx_strobe[1:0] = 2'b11;
        tick();
        bus.rx_strobe[1:0] = 2'b00;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: valid=%b chan=%0d, required valid 0",
                         k, bus.out_valid, bus.out_chan);
            end
            tick();
        end
        idle_inputs();
    endtask

    // One clock edge of the merging rules, from the inputs currently applied.
    task automatic model_step(input logic rst);
        bit free;
        int gnt;
        int c;
        logic [NRX-1:0] evt;
        if (rst) begin
            m_pend = '0; m_prev = '1; m_ovf = '0; m_last = NRX - 1;
            m_ov = 1'b0; m_oc = 0; m_or = 0; m_oi = 0;
            for (int i = 0; i < NRX; i++) begin m_hr[i] = 0; m_hi[i] = 0; end
            return;
        end
        free = !m_ov || bus.out_ready;
        gnt  = -1;
        if (free) begin
            for (int k = 1; k <= NRX; k++) begin
                c = (m_last + k) % NRX;
                if (gnt < 0 && m_pend[c] && bus.rx_enable[c]) gnt = c;
            end
            if (gnt >= 0) begin
                m_ov = 1'b1; m_oc = gnt; m_or = m_hr[gnt]; m_oi = m_hi[gnt]; m_last = gnt;
            end else begin
                m_ov = 1'b0;
            end
        end
        evt = '0;
        for (int i = 0; i < NRX; i++) begin
            if (!bus.rx_enable[i]) begin
                m_pend[i] = 1'b0;
            end else if (bus.rx_strobe[i] && !m_prev[i]) begin
                if (m_pend[i] && gnt != i) evt[i] = 1'b1;
                m_hr[i] = int'(bus.rx_real[24*i +: 24]);
                m_hi[i] = int'(bus.rx_imag[24*i +: 24]);
                m_pend[i] = 1'b1;
            end else if (gnt == i) begin
                m_pend[i] = 1'b0;
            end
        end
        m_ovf  = bus.overflow_clear ? evt : (m_ovf | evt);
        m_prev = bus.rx_strobe;
    endtask

    task automatic test_random();
        logic [NRX-1:0] strb;
        idle_inputs();
        reset = 1'b1;
        model_step(1'b1);
        tick();
        reset = 1'b0;
        strb = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NRX; i++) if ($urandom_range(0, 2) == 0) strb[i] = ~strb[i];
            bus.rx_strobe      = strb;
            bus.rx_enable      = ($urandom_range(0, 15) == 0) ? 4'($urandom) : '1;
            bus.out_ready      = ($urandom_range(0, 2) != 0);
            bus.overflow_clear = ($urandom_range(0, 19) == 0);
            bus.rx_real        = 96'({$urandom, $urandom, $urandom});
            bus.rx_imag        = 96'({$urandom, $urandom, $urandom});
            reset              = ($urandom_range(0, 299) == 0);
            model_step(reset);
            tick();
            n_checks++;
            if (bus.out_valid !== m_ov || bus.out_chan !== 3'(m_oc) ||
                bus.out_real !== 24'(m_or) || bus.out_imag !== 24'(m_oi)) begin
                n_fail++;
                $display("FAIL random_out[%0d]: got v=%b ch=%0d re=%h im=%h, model v=%b ch=%0d re=%h im=%h",
                         cyc, bus.out_valid, bus.out_chan, bus.out_real, bus.out_imag,
                         m_ov, m_oc, 24'(m_or), 24'(m_oi));
            end
            n_checks++;
            if (bus.overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random_ovf[%0d]: got %b, model %b", cyc, bus.overflow, m_ovf);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        bus.rx_real = '0;
        bus.rx_imag = '0;
        idle_inputs();
        test_reset();
        test_idle_latency();
        test_back_to_back();
        test_backpressure();
        test_strobe_through_reset();
        test_overflow_clear();
        test_enable_drop();
        test_reset_mid_transfer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
